// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Optional signed mode is enabled by defining DIV_SIGNED_EN.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    localparam logic [DIV_WIDTH-1:0] DBZ_Q = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sub.sv
// Trial subtractor for the divider: a - b with a borrow-out flag.
// Purely combinational; the controller registers everything it uses.
module div_sub
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    // Extra top bit of the widened difference is the borrow.
    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/div_seq_ctrl.sv
// Restoring divider controller: one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands (adds FIX state).
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] op_dd;
    logic [WIDTH-1:0] op_dv;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             fit;

`ifdef DIV_SIGNED_EN
    localparam div_state_e RUN_NEXT = FIX;
    logic neg_q;
    logic neg_r;

    // Iterate on magnitudes; signs are restored in FIX.
    assign op_dd = dividend[WIDTH-1] ? -dividend : dividend;
    assign op_dv = divisor[WIDTH-1] ? -divisor : divisor;
`else
    localparam div_state_e RUN_NEXT = DONE;

    assign op_dd = dividend;
    assign op_dv = divisor;
`endif

    div_sub #(.W(WIDTH + 1)) u_sub (
        .a      ({r, q[WIDTH-1]}),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    // Partial remainder stays below the divisor, so a fitting trial
    // never sets the top difference bit.
    assign fit = !borrow && !diff[WIDTH];

    assign quotient  = q;
    assign remainder = r;

    // Controller FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        count    <= '0;
                        dvs      <= op_dv;
`ifdef DIV_SIGNED_EN
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            q           <= DBZ_Q;
                            r           <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            q           <= op_dd;
                            r           <= '0;
                            div_by_zero <= 1'b0;
                            state       <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fit) begin
                        r <= diff[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= {r[WIDTH-2:0], q[WIDTH-1]};
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state     <= RUN_NEXT;
                        out_valid <= (RUN_NEXT == DONE);
                    end
                end
`ifdef DIV_SIGNED_EN
                FIX: begin
                    if (neg_q) q <= -q;
                    if (neg_r) r <= -r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
`endif
                DONE: begin
                    out_valid <= 1'b1;
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: vector table plus stall and reset cases.
// Expected values follow DIV_SIGNED_EN when the macro is defined.
module tb_div_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    typedef struct {
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    div_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Present operands at a falling edge once in_ready is up.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue.in_ready", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the acceptance edge to the first out_valid.
    task automatic wait_out(output int lat, output logic ir_seen);
        lat = 0;
        ir_seen = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) ir_seen = 1'b1;
        end while (!out_valid && lat < 200);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int   lat;
        logic irs;
        issue(v.dd, v.dv);
        wait_out(lat, irs);
        check($sformatf("v%0d.lat", i), lat, v.lat);
        check($sformatf("v%0d.q", i), quotient, v.q);
        check($sformatf("v%0d.r", i), remainder, v.r);
        check($sformatf("v%0d.dbz", i), div_by_zero, v.dbz);
        check($sformatf("v%0d.ready_low", i), irs, 0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d.consumed", i), out_valid, 0);
        check($sformatf("v%0d.ready_back", i), in_ready, 1);
    endtask

    initial begin
        int   lat;
        logic irs;
        logic bad;

`ifdef DIV_SIGNED_EN
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT};
        vecs[1] = '{32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, LAT};
        vecs[2] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, LAT};
        vecs[3] = '{32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1};
        vecs[4] = '{32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, LAT};
        vecs[5] = '{32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, LAT};
        vecs[6] = '{32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0, LAT};
        vecs[7] = '{32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1};
`else
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT};
        vecs[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, LAT};
        vecs[2] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, LAT};
        vecs[3] = '{32'd1234, 32'd0, 32'hFFFFFFFF, 32'd1234, 1'b1, 1};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, LAT};
        vecs[5] = '{32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0, LAT};
        vecs[6] = '{32'h12345678, 32'h10, 32'h01234567, 32'd8, 1'b0, LAT};
        vecs[7] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst.in_ready", in_ready, 1);
        check("rst.out_valid", out_valid, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dbz", div_by_zero, 0);

        // Table, back-to-back with out_ready held high
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Consumer stalls 10 cycles in DONE while new operands are offered
        out_ready = 1'b0;
        issue(32'd100, 32'd7);
        wait_out(lat, irs);
        check("stall.lat", lat, LAT);
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            dividend = 32'(k + 50);
            divisor  = 32'd1;
            @(posedge clk);
            #1;
            if (!out_valid || in_ready) bad = 1'b1;
            if (quotient !== 32'd14 || remainder !== 32'd2) bad = 1'b1;
        end
        check("stall.hold", bad, 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall.release_valid", out_valid, 0);
        check("stall.release_ready", in_ready, 1);
        bad = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) bad = 1'b1;
        end
        check("stall.no_restart", bad, 0);

        // Reset during RUN iteration 15
        issue(32'd100, 32'd7);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.q", quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst.in_ready", in_ready, 1);
        check("midrst.out_valid_after", out_valid, 0);
        check("midrst.r", remainder, 0);
        check("midrst.dbz", div_by_zero, 0);
        run_vec(100, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
